// File: rtl/obi_magic_mem_bridge_if.sv
// Bundle of the OBI core-side and magic-memory-side signals of obi_magic_mem_bridge.
// The bridge uses the slave modport; the core/memory model uses the master modport.
interface obi_magic_mem_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_i;
  logic                  gnt_o;
  logic                  we_i;
  logic [DATA_W/8-1:0]   be_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  err_o;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_resp;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, mem_resp, mem_rdata,
    output gnt_o, rvalid_o, rdata_o, err_o, mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, mem_resp, mem_rdata,
    input  gnt_o, rvalid_o, rdata_o, err_o, mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/obi_magic_mem_bridge.sv
// OBI req/gnt/rvalid to magic-memory bridge: queues granted requests, issues them one at a
// time with a one-cycle gap between accesses, and returns in-order responses (optional timeout).
module obi_magic_mem_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 0
) (
  input logic                     clk,
  input logic                     rst,
  obi_magic_mem_bridge_if.slave   bus
);

  localparam int unsigned BeW     = DATA_W / 8;
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned TmrW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TmrLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [TmrW-1:0]   timer_q;
  logic              rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              q_we    [DEPTH];
  logic [BeW-1:0]    q_be    [DEPTH];
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];

  logic full, push, pop, issue, resp_hit, tmo_hit, head_we;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    push     = bus.req_i & ~full;
    issue    = (state_q == StIssue);
    head_we  = q_we[rd_ptr_q];
    // X on mem_resp must never count as a response.
    resp_hit = issue & (bus.mem_resp === 1'b1);
    tmo_hit  = issue & ~resp_hit & (TIMEOUT != 0) & (timer_q == TmrW'(TmrLast));
    pop      = resp_hit | tmo_hit;
  end

  assign bus.gnt_o     = push;
  assign bus.mem_read  = issue & ~head_we;
  assign bus.mem_write = issue & head_we;
  assign bus.mem_mbe   = issue ? q_be[rd_ptr_q]    : '0;
  assign bus.mem_addr  = issue ? q_addr[rd_ptr_q]  : '0;
  assign bus.mem_wdata = issue ? q_wdata[rd_ptr_q] : '0;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop;
      err_q    <= tmo_hit;
      rdata_q  <= (resp_hit & ~head_we) ? bus.mem_rdata : '0;

      if (push) begin
        q_we[wr_ptr_q]    <= bus.we_i;
        q_be[wr_ptr_q]    <= bus.be_i;
        q_addr[wr_ptr_q]  <= bus.addr_i;
        q_wdata[wr_ptr_q] <= bus.wdata_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        // A push into an empty queue goes straight to ISSUE so the strobe rises next cycle.
        StIdle: begin
          if (count_q != '0 || push) begin
            state_q <= StIssue;
            timer_q <= '0;
          end
        end
        StIssue: begin
          if (pop) state_q <= StGap;
          else     timer_q <= timer_q + 1'b1;
        end
        StGap: begin
          if (count_q != '0) begin
            state_q <= StIssue;
            timer_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_magic_mem_bridge.sv
// Directed bench for obi_magic_mem_bridge (DEPTH=2, TIMEOUT=8); inputs change and outputs
// are checked around the falling edge.
module tb_obi_magic_mem_bridge;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  obi_magic_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  obi_magic_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(2), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_i   = r;
    bus.we_i    = w;
    bus.be_i    = be;
    bus.addr_i  = a;
    bus.wdata_i = d;
  endtask

  task automatic mresp(input logic r, input logic [31:0] d);
    bus.mem_resp  = r;
    bus.mem_rdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mresp(1'b0, 32'h0);
    step(); step(); #1;
    chk("rst_rvalid", bus.rvalid_o, 1'b0);
    chk("rst_read", bus.mem_read, 1'b0);
    chk("rst_write", bus.mem_write, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_gnt", bus.gnt_o, 1'b0);
    rst = 1'b0;
    step();

    // T1 single read, strobe up 3 cycles
    step(); drive(1'b1, 1'b0, 4'hF, 32'h80, 32'h0); #1;
    chk("t1_gnt", bus.gnt_o, 1'b1);
    chk("t1_read_pre", bus.mem_read, 1'b0);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t1_read_c1", bus.mem_read, 1'b1);
    chk("t1_addr", bus.mem_addr, 32'h80);
    chk("t1_mbe", bus.mem_mbe, 32'hF);
    chk("t1_write", bus.mem_write, 1'b0);
    step(); #1;
    chk("t1_read_c2", bus.mem_read, 1'b1);
    step(); mresp(1'b1, 32'hDEADBEEF); #1;
    chk("t1_read_c3", bus.mem_read, 1'b1);
    chk("t1_rvalid_early", bus.rvalid_o, 1'b0);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t1_read_gap", bus.mem_read, 1'b0);
    chk("t1_rvalid", bus.rvalid_o, 1'b1);
    chk("t1_rdata", bus.rdata_o, 32'hDEADBEEF);
    chk("t1_err", bus.err_o, 1'b0);
    step(); #1;
    chk("t1_rvalid_end", bus.rvalid_o, 1'b0);

    // T2 three back-to-back reads, queue of 2
    step(); drive(1'b1, 1'b0, 4'hF, 32'hA0, 32'h0); #1;
    chk("t2_gnt1", bus.gnt_o, 1'b1);
    step(); drive(1'b1, 1'b0, 4'hF, 32'hA4, 32'h0); #1;
    chk("t2_gnt2", bus.gnt_o, 1'b1);
    chk("t2_addr1", bus.mem_addr, 32'hA0);
    step(); drive(1'b1, 1'b0, 4'hF, 32'hA8, 32'h0); mresp(1'b1, 32'h1111_0001); #1;
    chk("t2_gnt3_full", bus.gnt_o, 1'b0);
    chk("t2_read1", bus.mem_read, 1'b1);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t2_gnt3", bus.gnt_o, 1'b1);
    chk("t2_gap1", bus.mem_read, 1'b0);
    chk("t2_rvalid1", bus.rvalid_o, 1'b1);
    chk("t2_rdata1", bus.rdata_o, 32'h1111_0001);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); mresp(1'b1, 32'h2222_0002); #1;
    chk("t2_rvalid_off", bus.rvalid_o, 1'b0);
    chk("t2_read2", bus.mem_read, 1'b1);
    chk("t2_addr2", bus.mem_addr, 32'hA4);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t2_gap2", bus.mem_read, 1'b0);
    chk("t2_rdata2", bus.rdata_o, 32'h2222_0002);
    step(); mresp(1'b1, 32'h3333_0003); #1;
    chk("t2_addr3", bus.mem_addr, 32'hA8);
    chk("t2_read3", bus.mem_read, 1'b1);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t2_rvalid3", bus.rvalid_o, 1'b1);
    chk("t2_rdata3", bus.rdata_o, 32'h3333_0003);
    step(); #1;
    chk("t2_idle", bus.mem_read, 1'b0);
    chk("t2_rvalid_end", bus.rvalid_o, 1'b0);

    // T3 write
    step(); drive(1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234); #1;
    chk("t3_gnt", bus.gnt_o, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); mresp(1'b1, 32'hFFFF_FFFF); #1;
    chk("t3_write", bus.mem_write, 1'b1);
    chk("t3_read", bus.mem_read, 1'b0);
    chk("t3_mbe", bus.mem_mbe, 32'h3);
    chk("t3_addr", bus.mem_addr, 32'h100);
    chk("t3_wdata", bus.mem_wdata, 32'h1234);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t3_rvalid", bus.rvalid_o, 1'b1);
    chk("t3_rdata", bus.rdata_o, 32'h0);
    chk("t3_err", bus.err_o, 1'b0);
    chk("t3_write_gap", bus.mem_write, 1'b0);
    step();

    // T4 timeout, then the queued write issues normally
    step(); drive(1'b1, 1'b0, 4'hF, 32'h200, 32'h0); #1;
    chk("t4_gnt1", bus.gnt_o, 1'b1);
    step(); drive(1'b1, 1'b1, 4'hF, 32'h204, 32'h55); #1;
    chk("t4_gnt2", bus.gnt_o, 1'b1);
    chk("t4_read_c1", bus.mem_read, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    chk("t4_read_c2", bus.mem_read, 1'b1);
    for (int i = 3; i <= 8; i++) begin
      step(); #1;
      chk($sformatf("t4_read_c%0d", i), bus.mem_read, 1'b1);
      chk($sformatf("t4_norv_c%0d", i), bus.rvalid_o, 1'b0);
    end
    step(); #1;
    chk("t4_read_gap", bus.mem_read, 1'b0);
    chk("t4_rvalid", bus.rvalid_o, 1'b1);
    chk("t4_err", bus.err_o, 1'b1);
    chk("t4_rdata", bus.rdata_o, 32'h0);
    step(); mresp(1'b1, 32'h0); #1;
    chk("t4_next_write", bus.mem_write, 1'b1);
    chk("t4_next_addr", bus.mem_addr, 32'h204);
    chk("t4_next_wdata", bus.mem_wdata, 32'h55);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t4_next_rvalid", bus.rvalid_o, 1'b1);
    chk("t4_next_err", bus.err_o, 1'b0);
    step();

    // T4b response on the expiry cycle wins
    step(); drive(1'b1, 1'b0, 4'hF, 32'h300, 32'h0); #1;
    chk("t4b_gnt", bus.gnt_o, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 2; i <= 7; i++) step();
    step(); mresp(1'b1, 32'hCAFEF00D); #1;
    chk("t4b_read_c8", bus.mem_read, 1'b1);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t4b_rvalid", bus.rvalid_o, 1'b1);
    chk("t4b_err", bus.err_o, 1'b0);
    chk("t4b_rdata", bus.rdata_o, 32'hCAFEF00D);
    step();

    // T5 resp pulse in IDLE and X during ISSUE are ignored
    step(); mresp(1'b1, 32'h9999_9999); #1;
    step(); mresp(1'b0, 32'h0); #1;
    chk("t5_idle_norv", bus.rvalid_o, 1'b0);
    chk("t5_idle_noread", bus.mem_read, 1'b0);
    drive(1'b1, 1'b0, 4'hF, 32'h400, 32'h0); #1;
    chk("t5_gnt", bus.gnt_o, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); bus.mem_resp = 1'bx; #1;
    chk("t5_read_x", bus.mem_read, 1'b1);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t5_x_norv", bus.rvalid_o, 1'b0);
    chk("t5_x_still_read", bus.mem_read, 1'b1);
    mresp(1'b1, 32'h4444_0004);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t5_rvalid", bus.rvalid_o, 1'b1);
    chk("t5_rdata", bus.rdata_o, 32'h4444_0004);
    step();

    // T6 reset during ISSUE with two queued
    step(); drive(1'b1, 1'b0, 4'hF, 32'h500, 32'h0); #1;
    chk("t6_gnt1", bus.gnt_o, 1'b1);
    step(); drive(1'b1, 1'b0, 4'hF, 32'h504, 32'h0); #1;
    chk("t6_gnt2", bus.gnt_o, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); rst = 1'b1; #1;
    chk("t6_read_pre", bus.mem_read, 1'b1);
    step(); rst = 1'b0; #1;
    chk("t6_read", bus.mem_read, 1'b0);
    chk("t6_write", bus.mem_write, 1'b0);
    chk("t6_addr", bus.mem_addr, 32'h0);
    chk("t6_rvalid", bus.rvalid_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk($sformatf("t6_quiet_rv%0d", i), bus.rvalid_o, 1'b0);
      chk($sformatf("t6_quiet_rd%0d", i), bus.mem_read, 1'b0);
    end
    drive(1'b1, 1'b0, 4'hF, 32'h600, 32'h0); #1;
    chk("t6_gnt_new", bus.gnt_o, 1'b1);
    step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); mresp(1'b1, 32'h6666_0006); #1;
    chk("t6_new_addr", bus.mem_addr, 32'h600);
    step(); mresp(1'b0, 32'h0); #1;
    chk("t6_new_rvalid", bus.rvalid_o, 1'b1);
    chk("t6_new_rdata", bus.rdata_o, 32'h6666_0006);
    step(); #1;
    chk("t6_end_idle", bus.mem_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
